// File: rtl/load_store_unit.sv
// Load/store initiator between the CPU and a word-addressed data memory.
// Sub-word stores are done as read-modify-write because the memory only writes whole words.
module load_store_unit #(
  parameter int MEM_BYTES = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] mem_ReadData
);

  localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wword_q, wword_d;

  logic        bad_req;
  logic [31:0] rd_shift, wr_shift, merged;
  logic [3:0]  lane_mask;

  always_comb begin
    bad_req = (size == 2'd3) || (addr >= MEM_LIMIT) ||
              (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    wword_d = wword_q;

    // Align the addressed lane to bit 0 for loads, and wdata up to its lane for stores.
    rd_shift  = mem_ReadData >> {addr_q[1:0], 3'b000};
    wr_shift  = wdata_q << {addr_q[1:0], 3'b000};
    lane_mask = (size_q == 2'd0) ? (4'b0001 << addr_q[1:0]) : (4'b0011 << addr_q[1:0]);
    merged    = mem_ReadData;
    for (int k = 0; k < 4; k++) begin
      if (lane_mask[k]) merged[8*k +: 8] = wr_shift[8*k +: 8];
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = bad_req;
          if (bad_req)                    state_d = FIN;
          else if (we && size == 2'd2) begin
            wword_d = wdata;
            state_d = WR;
          end else                        state_d = RD;
        end
      end
      RD: begin
        if (we_q) begin
          wword_d = merged;
          state_d = WR;
        end else begin
          case (size_q)
            2'd0:    rdata_d = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rdata_d = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rdata_d = mem_ReadData;
          endcase
          state_d = FIN;
        end
      end
      WR:  state_d = FIN;
      FIN: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      wword_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wword_q <= wword_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign done          = (state_q == FIN);
  assign err           = (state_q == FIN) & err_q;
  assign rdata         = rdata_q;
  assign mem_MemRead   = (state_q == RD);
  // Gated by reset so a write in flight can never land while reset is asserted.
  assign mem_MemWrite  = (state_q == WR) & ~reset;
  assign mem_address   = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_WriteData = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset-abort sequence and random traffic
// compared against a byte-array reference model of the memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        ready, done, err, mem_MemRead, mem_MemWrite;
  logic [31:0] rdata, mem_address, mem_WriteData, mem_ReadData;

  load_store_unit #(.MEM_BYTES(512)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  always #5 clock = ~clock;

  // Word memory seen by the DUT
  logic [31:0] tb_mem [0:127];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_idx = 7'd0;
  logic [31:0] pre_dat = 32'd0;
  int          wr_total = 0;

  assign mem_ReadData = tb_mem[mem_address[8:2]];

  always @(posedge clock) begin
    if (pre_en) tb_mem[pre_idx] <= pre_dat;
    else if (mem_MemWrite) begin
      tb_mem[mem_address[8:2]] <= mem_WriteData;
      wr_total <= wr_total + 1;
    end
  end

  // Reference model: flat byte array plus last completed load value
  logic [7:0]  ref_mem [0:511];
  logic [31:0] last_rdata = 32'd0;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int k);
    return {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
  endfunction

  task automatic model(input logic w, input logic [1:0] sz, input logic se, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd, output int lat);
    int nb, base;
    logic [31:0] v;
    e  = (sz == 2'd3) || (a >= 32'd512) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    nb = 1 << sz;
    base = int'(a[8:0]);
    if (e) lat = 1;
    else if (w) begin
      for (int i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
      lat = (sz == 2'd2) ? 2 : 3;
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8*i));
      if (nb < 4 && se && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
      last_rdata = v;
      lat = 2;
    end
    rd = last_rdata;
  endtask

  task automatic run(input string name, input logic w, input logic [1:0] sz, input logic se,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic exp_e, input logic [31:0] exp_rd, input int exp_lat);
    int lat, nrd, nwr;
    logic addr_ok, both, got_e;
    logic [31:0] got_rd, r;
    lat = 0; nrd = 0; nwr = 0; addr_ok = 1'b1; both = 1'b0; got_e = 1'b0; got_rd = 32'd0;
    @(negedge clock);
    chk({name, " ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    @(posedge clock);
    #1;
    r = $urandom;
    req = 1'b0; we = r[0]; size = r[2:1]; sign_ext = r[3]; addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (mem_MemRead) nrd++;
      if (mem_MemWrite) nwr++;
      if (mem_MemRead && mem_MemWrite) both = 1'b1;
      if ((mem_MemRead || mem_MemWrite) && mem_address !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      if (done) begin
        lat = c; got_e = err; got_rd = rdata;
        break;
      end
    end
    if (lat == 0) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within 8 cycles", name);
    end else begin
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " err"}, 32'(got_e), 32'(exp_e));
      chk({name, " rdata"}, got_rd, exp_rd);
    end
    chk({name, " reads"}, 32'(nrd), (!exp_e && (!w || sz != 2'd2)) ? 32'd1 : 32'd0);
    chk({name, " writes"}, 32'(nwr), (!exp_e && w) ? 32'd1 : 32'd0);
    chk({name, " addr/excl"}, {30'd0, addr_ok, both}, 32'd2);
    if (a < 32'd512) chk({name, " memword"}, tb_mem[a[8:2]], ref_word(int'(a[8:2])));
  endtask

  typedef struct {
    logic w; logic [1:0] sz; logic se; logic [31:0] a; logic [31:0] wd;
    logic [31:0] rd; logic e; int lat;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic e;
    logic [31:0] rd, a, wd, r;
    logic [1:0] sz;
    int lat, wr_before, bad;

    tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h009, 32'h0,        32'hFFFFFFAA, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h009, 32'h0,        32'h000000AA, 1'b0, 2};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 32'h00A, 32'h0,        32'hFFFF8899, 1'b0, 2};
    tbl[3]  = '{1'b0, 2'd2, 1'b1, 32'h008, 32'h0,        32'h8899AABB, 1'b0, 2};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h012, 32'h000000EE, 32'h8899AABB, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h11EE3344, 1'b0, 2};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h010, 32'h0000BEEF, 32'h11EE3344, 1'b0, 3};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h11EEBEEF, 1'b0, 2};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h1FC, 32'hDEADBEEF, 32'h11EEBEEF, 1'b0, 2};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h006, 32'h0,        32'hDEADBEEF, 1'b1, 1};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h003, 32'h12345678, 32'hDEADBEEF, 1'b1, 1};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h0,        32'hDEADBEEF, 1'b1, 1};
    tbl[13] = '{1'b1, 2'd3, 1'b0, 32'h000, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 1};

    // Preload memory while reset is held
    for (int k = 0; k < 128; k++) begin
      @(negedge clock);
      r = (k == 2) ? 32'h8899AABB : (k == 4) ? 32'h11223344 : $urandom;
      pre_en = 1'b1; pre_idx = 7'(k); pre_dat = r;
      for (int b = 0; b < 4; b++) ref_mem[4*k + b] = r[8*b +: 8];
    end
    @(negedge clock);
    pre_en = 1'b0;

    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done/err", {30'd0, done, err}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset strobes", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    chk("reset WriteData", mem_WriteData, 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].a, tbl[i].wd, e, rd, lat);
      run($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].a, tbl[i].wd,
          tbl[i].e, tbl[i].rd, tbl[i].lat);
    end

    // sb aborted by reset in its WR cycle, with a load request held through reset
    @(negedge clock);
    wr_before = wr_total;
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h021; wdata = 32'h00000055;
    @(negedge clock);
    req = 1'b0;
    chk("abort RD strobe", 32'(mem_MemRead), 32'd1);
    @(negedge clock);
    chk("abort WR strobe", 32'(mem_MemWrite), 32'd1);
    reset = 1'b1;
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h010;
    #1;
    chk("abort write gated", 32'(mem_MemWrite), 32'd0);
    @(negedge clock);
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort done/err", {30'd0, done, err}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    chk("abort outputs", {mem_address | mem_WriteData}, 32'd0);
    chk("abort strobes", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    last_rdata = 32'd0;
    @(negedge clock);
    chk("held req in reset", {30'd0, mem_MemRead, done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    req = 1'b0;
    chk("held req RD", {31'd0, mem_MemRead}, 32'd1);
    chk("held req addr", mem_address, 32'h010);
    @(negedge clock);
    chk("held req done", {30'd0, done, err}, 32'd2);
    chk("held req rdata", rdata, ref_word(4));
    last_rdata = ref_word(4);
    chk("abort no write", 32'(wr_total - wr_before), 32'd0);
    chk("abort memword", tb_mem[8], ref_word(8));

    // Random traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      r  = $urandom;
      sz = r[1:0];
      a  = 32'($urandom_range(0, 600));
      if (r[3:2] != 2'b00 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      model(r[4], sz, r[5], a, wd, e, rd, lat);
      run($sformatf("rand%0d", n), r[4], sz, r[5], a, wd, e, rd, lat);
    end

    bad = 0;
    for (int k = 0; k < 128; k++) if (tb_mem[k] !== ref_word(k)) bad++;
    chk("final memory sweep", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access initiator between the CPU datapath and the word-addressed data memory.
- Accepts load/store requests of byte, halfword or word size from the CPU.
- Drives the memory's address, MemRead, MemWrite and WriteData strobes, and returns sign- or zero-extended load data.
- Sub-word stores use a read-modify-write sequence, because the memory only writes whole words.

Parameters:
- MEM_BYTES, 512: addressable data memory size in bytes. Requests with addr >= MEM_BYTES are errors.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid. Sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = halfword, 2 = word. Value 3 is an error.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- ready  out  1  unit idle; a request is accepted this cycle if req=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: request was misaligned, out of range, or used size=3.
- rdata  out  32  load result; valid when done=1 and we was 0; holds its value until the next load completes.
- mem_address  out  32  word-aligned address to memory (bits [1:0] always 0).
- mem_MemRead  out  1  memory read strobe.
- mem_MemWrite  out  1  memory write strobe.
- mem_WriteData  out  32  full word to write.
- mem_ReadData  in  32  combinational read data from memory for mem_address.

Behaviour:
- Reset values:
  - ready=1; done=0; err=0; rdata=0.
  - mem_address=0; mem_MemRead=0; mem_MemWrite=0; mem_WriteData=0.
  - state=IDLE.
- Reset in any state returns to IDLE the next cycle and abandons the request without a done pulse.
- mem_MemWrite is combinationally forced to 0 while reset=1, so no memory write occurs in a cycle where reset is high.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - ready=1. On req=1, latch we, size, sign_ext, addr and wdata.
  - Misaligned request (size=1 with addr[0]=1, or size=2 with addr[1:0]!=0), out-of-range addr, or size=3: go to FIN with err pending. No memory strobes are asserted.
  - Load, or sub-word store: go to RD.
  - Word store: go to WR with mem_WriteData=wdata.
- RD (1 cycle):
  - mem_MemRead=1, mem_MemWrite=0, mem_address={addr[31:2],2'b00}.
  - At the clock edge, mem_ReadData is captured.
  - Load: extract the lane, extend it into rdata, then go to FIN.
  - Sub-word store: merge wdata into the captured word at the selected lane, leave the other bytes unchanged, place the result in mem_WriteData, then go to WR.
- WR (1 cycle): mem_MemWrite=1, mem_MemRead=0, same mem_address. The memory commits at the end of this cycle. Then go to FIN.
- FIN (1 cycle): done=1, err as computed, all strobes 0. Then go to IDLE.
- MemRead and MemWrite are never both 1.
- Lane order is little-endian:
  - byte k occupies bits [8k+7:8k], with k=addr[1:0];
  - the halfword at addr[1]=h occupies bits [16h+15:16h].
- Extension: sign_ext=1 replicates the lane's MSB into the upper bits; sign_ext=0 fills them with 0. Word loads ignore sign_ext.
- Latency from the accept cycle N:
  - load: done at N+2;
  - word store: done at N+2;
  - sub-word store: done at N+3;
  - error: done at N+1.
- req is ignored while ready=0 and must be held by the requester until it is accepted.
- The next request can be accepted in the cycle after the done pulse, when the unit is back in IDLE.
- Latched request fields are immune to input changes after the accept cycle.

Test Plan:
- Memory word at 0x08 = 0x8899AABB; lb, sign_ext=1, addr 0x09 -> done at N+2, rdata=0xFFFFFFAA, err=0. lbu at the same address -> rdata=0x000000AA.
- Same word; lh, sign_ext=1, addr 0x0A -> rdata=0xFFFF8899. lw at addr 0x08 -> rdata=0x8899AABB. Check mem_MemRead=1 only in the RD cycle.
- Word at 0x10 = 0x11223344; sb wdata=0x000000EE at addr 0x12 -> RD then WR, memory word becomes 0x11EE3344, done at N+3. sh 0xBEEF at 0x10 -> word becomes 0x11EEBEEF.
- sw 0xDEADBEEF at addr 0x1FC -> exactly one MemWrite cycle at mem_address 0x1FC, done at N+2. Read back 0xDEADBEEF.
- lw at 0x06, sh at 0x03, lb at 0x200, and size=3 -> each gives done+err at N+1, mem_MemRead and mem_MemWrite stay 0, and memory is unchanged.
- Start an sb, assert reset during the WR cycle -> no memory write, no done pulse, ready=1 next cycle, all outputs at reset values. A req held through reset is accepted only after reset deasserts.
